// File: rtl/ysyx_25040129_issue_scoreboard.sv
// Issue scoreboard: pending-write counters, youngest-first operand forwarding,
// RAW/WAW stall generation and a registered valid/ready output slot toward EXU.
module ysyx_25040129_issue_scoreboard #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 16,
    parameter int REG_AW     = 4,
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REG_AW-1:0]            in_src1_id,
    input  logic [REG_AW-1:0]            in_src2_id,
    input  logic                         in_src1_use,
    input  logic                         in_src2_use,
    input  logic [XLEN-1:0]              in_src1_reg,
    input  logic [XLEN-1:0]              in_src2_reg,
    input  logic [REG_AW-1:0]            in_rd,
    input  logic                         in_rd_we,
    input  logic [FWD_STAGES*REG_AW-1:0] fwd_rd,
    input  logic [FWD_STAGES-1:0]        fwd_we,
    input  logic [FWD_STAGES-1:0]        fwd_dvalid,
    input  logic [FWD_STAGES*XLEN-1:0]   fwd_data,
    input  logic                         retire_valid,
    input  logic [REG_AW-1:0]            retire_rd,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_src1,
    output logic [XLEN-1:0]              out_src2,
    output logic [REG_AW-1:0]            out_rd,
    output logic                         out_rd_we,
    output logic                         sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pending [NREGS];

    logic            haz1, haz2, waw, hazard;
    logic [XLEN-1:0] opnd1, opnd2;
    logic            issue, retire;
    logic [NREGS-1:0] inc_vec, dec_vec;

    // Returns {hazard, operand}. The loop walks oldest to youngest so the
    // lowest-index matching stage is the one that sticks.
    function automatic logic [XLEN:0] resolve(
        input logic                         use_src,
        input logic [REG_AW-1:0]            id,
        input logic [XLEN-1:0]              reg_data,
        input logic [CNT_W-1:0]             pend,
        input logic [FWD_STAGES*REG_AW-1:0] f_rd,
        input logic [FWD_STAGES-1:0]        f_we,
        input logic [FWD_STAGES-1:0]        f_dv,
        input logic [FWD_STAGES*XLEN-1:0]   f_data
    );
        logic            hit;
        logic            haz;
        logic [XLEN-1:0] val;
        hit = 1'b0;
        haz = 1'b0;
        val = reg_data;
        if (use_src && id != '0) begin
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (f_we[k] && f_rd[k*REG_AW +: REG_AW] == id) begin
                    hit = 1'b1;
                    haz = !f_dv[k];
                    val = f_data[k*XLEN +: XLEN];
                end
            end
            if (!hit && pend != '0) haz = 1'b1;
        end
        return {haz, val};
    endfunction

    always_comb begin
        {haz1, opnd1} = resolve(in_src1_use, in_src1_id, in_src1_reg, pending[in_src1_id],
                                fwd_rd, fwd_we, fwd_dvalid, fwd_data);
        {haz2, opnd2} = resolve(in_src2_use, in_src2_id, in_src2_reg, pending[in_src2_id],
                                fwd_rd, fwd_we, fwd_dvalid, fwd_data);
        waw      = in_rd_we && (in_rd != '0) && (pending[in_rd] == CNT_MAX);
        hazard   = haz1 || haz2 || waw;
        in_ready = !flush && !hazard && (!out_valid || out_ready);
        issue    = in_valid && in_ready;
        retire   = retire_valid && (retire_rd != '0) && !flush;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue && in_rd_we && in_rd != '0) inc_vec[in_rd] = 1'b1;
        if (retire) dec_vec[retire_rd] = 1'b1;
    end

    // Simultaneous issue and retire on one register cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) pending[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < NREGS; r++) pending[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    pending[r] <= pending[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && pending[r] != '0)
                    pending[r] <= pending[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_err <= 1'b0;
        else if (retire && pending[retire_rd] == '0)
            sb_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_src1  <= opnd1;
            out_src2  <= opnd2;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_issue_scoreboard.sv
// Self-checking bench for the issue scoreboard: directed scenarios plus a
// randomized run, all checked against a per-register bookkeeping model.
module tb_ysyx_25040129_issue_scoreboard;

    localparam int FS   = 3;
    localparam int NR   = 16;
    localparam int CMAX = 3;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_src1_id, in_src2_id, in_rd, retire_rd, out_rd;
    logic        in_src1_use, in_src2_use, in_rd_we;
    logic [31:0] in_src1_reg, in_src2_reg, out_src1, out_src2;
    logic [11:0] fwd_rd;
    logic [2:0]  fwd_we, fwd_dvalid;
    logic [95:0] fwd_data;
    logic        retire_valid, flush, out_valid, out_ready, out_rd_we, sb_err;

    logic [3:0]  f_rd   [FS];
    logic        f_we   [FS];
    logic        f_dv   [FS];
    logic [31:0] f_data [FS];

    int          m_pend [NR];
    bit          m_ov, m_we, m_err;
    logic [31:0] m_s1, m_s2;
    logic [3:0]  m_rd;
    int          n_pass, n_total;

    ysyx_25040129_issue_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_src1_id(in_src1_id), .in_src2_id(in_src2_id),
        .in_src1_use(in_src1_use), .in_src2_use(in_src2_use),
        .in_src1_reg(in_src1_reg), .in_src2_reg(in_src2_reg),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_dvalid(fwd_dvalid), .fwd_data(fwd_data),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        fwd_rd = '0; fwd_we = '0; fwd_dvalid = '0; fwd_data = '0;
        for (int k = 0; k < FS; k++) begin
            fwd_rd[k*4 +: 4]    = f_rd[k];
            fwd_we[k]           = f_we[k];
            fwd_dvalid[k]       = f_dv[k];
            fwd_data[k*32 +: 32] = f_data[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Operand lookup straight from the rules: first matching stage wins,
    // otherwise an outstanding writer blocks, otherwise register data.
    function automatic bit m_src(input bit use_s, input logic [3:0] id,
                                 input logic [31:0] rdata, output logic [31:0] v);
        v = rdata;
        if (!use_s || id == 0) return 1'b0;
        for (int k = 0; k < FS; k++)
            if (f_we[k] && f_rd[k] == id) begin
                v = f_data[k];
                return !f_dv[k];
            end
        return m_pend[id] > 0;
    endfunction

    function automatic bit m_ready();
        logic [31:0] d;
        bit h1, h2, w;
        h1 = m_src(in_src1_use, in_src1_id, in_src1_reg, d);
        h2 = m_src(in_src2_use, in_src2_id, in_src2_reg, d);
        w  = in_rd_we && in_rd != 0 && m_pend[in_rd] == CMAX;
        return !flush && !h1 && !h2 && !w && (!m_ov || out_ready);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_pend[r] = 0;
        m_ov = 0; m_we = 0; m_err = 0; m_s1 = '0; m_s2 = '0; m_rd = '0;
    endtask

    task automatic idle();
        in_valid = 0; in_src1_id = 0; in_src2_id = 0; in_src1_use = 0; in_src2_use = 0;
        in_src1_reg = $urandom; in_src2_reg = $urandom; in_rd = 0; in_rd_we = 0;
        retire_valid = 0; retire_rd = 0; flush = 0; out_ready = 1;
        for (int k = 0; k < FS; k++) begin
            f_rd[k] = 0; f_we[k] = 0; f_dv[k] = 0; f_data[k] = $urandom;
        end
    endtask

    // One clock: evaluate the model on the pre-edge inputs, advance, settle.
    task automatic cycle();
        bit iss, inc, dec;
        logic [31:0] d1, d2;
        iss = in_valid && m_ready();
        void'(m_src(in_src1_use, in_src1_id, in_src1_reg, d1));
        void'(m_src(in_src2_use, in_src2_id, in_src2_reg, d2));
        @(posedge clk);
        if (flush) begin
            for (int r = 0; r < NR; r++) m_pend[r] = 0;
            m_ov = 0;
        end else begin
            inc = iss && in_rd_we && in_rd != 0;
            dec = retire_valid && retire_rd != 0;
            if (dec && m_pend[retire_rd] == 0) m_err = 1;
            if (!(inc && dec && in_rd == retire_rd)) begin
                if (dec && m_pend[retire_rd] > 0) m_pend[retire_rd]--;
                if (inc) m_pend[in_rd]++;
            end
            if (iss) begin
                m_ov = 1; m_s1 = d1; m_s2 = d2; m_rd = in_rd; m_we = in_rd_we;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); model_reset();
        #12;
        n_total++;
        if ({out_valid, out_src1, out_src2, out_rd, out_rd_we, sb_err} !== '0)
            $display("FAIL reset_outputs: got v=%b s1=%h s2=%h rd=%h we=%b err=%b, expected all zero",
                     out_valid, out_src1, out_src2, out_rd, out_rd_we, sb_err);
        else n_pass++;
        rst_n = 1;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        idle();
        in_valid = 1; in_rd = 5; in_rd_we = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL basic_ready: got %b expected 1", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_valid !== 1'b1 || out_rd !== 4'd5 || out_rd_we !== 1'b1)
            $display("FAIL basic_issue: got v=%b rd=%0d we=%b expected v=1 rd=5 we=1", out_valid, out_rd, out_rd_we);
        else n_pass++;
        in_rd_we = 0; in_rd = 0; in_src1_use = 1; in_src1_id = 5;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL basic_pending_stall: got %b expected 0", in_ready); else n_pass++;
        in_valid = 0; retire_valid = 1; retire_rd = 5;
        cycle();
        retire_valid = 0; in_valid = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL basic_after_retire: got %b expected 1", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_src1 !== in_src1_reg || out_src1 !== m_s1 || sb_err !== 1'b0)
            $display("FAIL basic_regdata: got s1=%h err=%b expected s1=%h err=0", out_src1, sb_err, m_s1);
        else n_pass++;
    endtask

    task automatic test_forward();
        idle();
        f_we[0] = 1; f_rd[0] = 3; f_dv[0] = 1; f_data[0] = 32'h1234;
        in_valid = 1; in_src1_use = 1; in_src1_id = 3; in_src1_reg = 32'hDEAD;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL fwd_ready: got %b expected 1", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_src1 !== 32'h1234 || out_src1 !== m_s1)
            $display("FAIL fwd_hit: got %h expected 00001234", out_src1);
        else n_pass++;
        f_we[2] = 1; f_rd[2] = 3; f_dv[2] = 1; f_data[2] = 32'hFFFF; in_src1_reg = 32'hBEEF;
        cycle();
        n_total++;
        if (out_src1 !== 32'h1234 || out_src1 !== m_s1)
            $display("FAIL fwd_youngest: got %h expected 00001234", out_src1);
        else n_pass++;
    endtask

    task automatic test_load_use();
        idle();
        f_we[1] = 1; f_rd[1] = 7; f_dv[1] = 0;
        in_valid = 1; in_src2_use = 1; in_src2_id = 7;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL loaduse_stall: got %b expected 0", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL loaduse_no_issue: got out_valid=%b expected 0", out_valid); else n_pass++;
        f_dv[1] = 1; f_data[1] = 32'hAB;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL loaduse_release: got %b expected 1", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_valid !== 1'b1 || out_src2 !== 32'hAB)
            $display("FAIL loaduse_data: got v=%b s2=%h expected v=1 s2=000000ab", out_valid, out_src2);
        else n_pass++;
    endtask

    task automatic test_out_of_window();
        idle();
        in_valid = 1; in_rd = 9; in_rd_we = 1;
        cycle();
        in_rd = 0; in_rd_we = 0; in_src1_use = 1; in_src1_id = 9; in_src1_reg = 32'h99;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL oow_stall: got %b expected 0", in_ready); else n_pass++;
        retire_valid = 1; retire_rd = 9;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL oow_retire_comb: got %b expected 0", in_ready); else n_pass++;
        cycle();
        retire_valid = 0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL oow_release: got %b expected 1", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_src1 !== 32'h99) $display("FAIL oow_regdata: got %h expected 00000099", out_src1); else n_pass++;
    endtask

    task automatic test_saturation();
        idle();
        in_valid = 1; in_rd = 4; in_rd_we = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL sat_fill%0d: got %b expected 1", i, in_ready); else n_pass++;
            cycle();
        end
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL sat_full: got %b expected 0", in_ready); else n_pass++;
        in_valid = 0; retire_valid = 1; retire_rd = 4;
        cycle();
        in_valid = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL sat_simul_ready: got %b expected 1", in_ready); else n_pass++;
        cycle();
        retire_valid = 0;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || in_ready !== m_ready())
            $display("FAIL sat_net_zero: got %b expected 1", in_ready);
        else n_pass++;
        cycle();
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL sat_refull: got %b expected 0", in_ready); else n_pass++;
        in_rd_we = 0; in_rd = 0; in_src1_use = 1; in_src1_id = 0; in_src1_reg = 0;
        f_we[0] = 1; f_rd[0] = 0; f_dv[0] = 0; f_data[0] = 32'h5555;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL zero_src_ready: got %b expected 1", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_src1 !== 32'h0) $display("FAIL zero_src_data: got %h expected 00000000", out_src1); else n_pass++;
    endtask

    task automatic test_random();
        int q[$];
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(1, 0) == 1;
            in_src1_id = 4'($urandom_range(7, 0)); in_src2_id = 4'($urandom_range(7, 0));
            in_src1_use = $urandom_range(1, 0) == 1; in_src2_use = $urandom_range(1, 0) == 1;
            in_src1_reg = $urandom; in_src2_reg = $urandom;
            in_rd = 4'($urandom_range(7, 0)); in_rd_we = $urandom_range(1, 0) == 1;
            for (int k = 0; k < FS; k++) begin
                f_rd[k] = 4'($urandom_range(7, 0)); f_we[k] = $urandom_range(2, 0) == 0;
                f_dv[k] = $urandom_range(3, 0) != 0; f_data[k] = $urandom;
            end
            q.delete();
            for (int r = 1; r < NR; r++) if (m_pend[r] > 0) q.push_back(r);
            retire_valid = q.size() > 0 && $urandom_range(1, 0) == 1;
            retire_rd = (q.size() > 0) ? 4'(q[$urandom_range(q.size() - 1, 0)]) : 4'd0;
            flush = $urandom_range(29, 0) == 0;
            out_ready = $urandom_range(3, 0) != 0;
            #1;
            n_total++;
            if (in_ready !== m_ready())
                $display("FAIL rand_ready c=%0d: got %b expected %b", c, in_ready, m_ready());
            else n_pass++;
            cycle();
            n_total++;
            if ({out_valid, out_rd_we, out_rd, out_src1, out_src2, sb_err} !== {m_ov, m_we, m_rd, m_s1, m_s2, m_err})
                $display("FAIL rand_out c=%0d: got v=%b we=%b rd=%h s1=%h s2=%h err=%b expected v=%b we=%b rd=%h s1=%h s2=%h err=%b",
                         c, out_valid, out_rd_we, out_rd, out_src1, out_src2, sb_err,
                         m_ov, m_we, m_rd, m_s1, m_s2, m_err);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure_flush_err();
        idle();
        out_ready = 0; in_valid = 1; in_rd = 6; in_rd_we = 1; in_src1_use = 1; in_src1_id = 1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            in_src1_reg = $urandom; in_src2_reg = $urandom; in_rd = 4'($urandom_range(15, 1));
            #1;
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b expected 0", i, in_ready); else n_pass++;
            cycle();
            n_total++;
            if ({out_valid, out_rd, out_rd_we, out_src1, out_src2} !== {1'b1, 4'd6, 1'b1, m_s1, m_s2})
                $display("FAIL bp_stable%0d: got v=%b rd=%0d s1=%h s2=%h expected v=1 rd=6 s1=%h s2=%h",
                         i, out_valid, out_rd, out_src1, out_src2, m_s1, m_s2);
            else n_pass++;
        end
        flush = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", in_ready); else n_pass++;
        cycle();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else n_pass++;
        flush = 0; out_ready = 1; in_rd_we = 0; in_src1_id = 6;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL flush_counters: got %b expected 1", in_ready); else n_pass++;
        cycle();
        in_valid = 0; retire_valid = 1; retire_rd = 2;
        cycle();
        retire_valid = 0;
        n_total++;
        if (sb_err !== 1'b1) $display("FAIL err_set: got %b expected 1", sb_err); else n_pass++;
        flush = 1;
        cycle();
        flush = 0;
        n_total++;
        if (sb_err !== 1'b1) $display("FAIL err_through_flush: got %b expected 1", sb_err); else n_pass++;
        in_valid = 1; in_rd = 8; in_rd_we = 1;
        cycle();
        #2;
        rst_n = 0;
        #1;
        n_total++;
        if ({out_valid, out_src1, out_src2, out_rd, out_rd_we, sb_err} !== '0)
            $display("FAIL async_reset: got v=%b s1=%h s2=%h rd=%h we=%b err=%b expected all zero",
                     out_valid, out_src1, out_src2, out_rd, out_rd_we, sb_err);
        else n_pass++;
        model_reset(); idle();
        #3;
        rst_n = 1;
        @(posedge clk); #1;
        in_valid = 1; in_src1_use = 1; in_src1_id = 8;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_clears_pending: got %b expected 1", in_ready); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_out_of_window();
        test_saturation();
        test_random();
        test_backpressure_flush_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_issue_scoreboard.md
Name:
ysyx_25040129_issue_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard/forward logic.
- Tracks in-flight register writes with per-register saturating pending counters. This covers writers still outside the forwarding window (multi-cycle units).
- Selects forwarded operands from FWD_STAGES later stages, youngest first, and stalls issue on unresolved RAW hazards or counter overflow.
- Issued operands are registered into an output slot with a valid/ready handshake to EXU.

Parameters:
- XLEN, 32, operand/data width
- NREGS, 16, architectural register count (register 0 hardwired zero)
- REG_AW, 4, register-id width, equal to clog2(NREGS)
- FWD_STAGES, 3, number of forwarding sources; index 0 is youngest (EXU), then LSU, then WBU
- CNT_W, 2, pending-counter width; at most 2^CNT_W-1 writers in flight per register

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction valid from IDU
- in_ready  out  1  scoreboard can accept instruction
- in_src1_id, in_src2_id  in  REG_AW each  source register ids
- in_src1_use, in_src2_use  in  1 each  source read from register file
- in_src1_reg, in_src2_reg  in  XLEN each  register file read data
- in_rd  in  REG_AW  destination id
- in_rd_we  in  1  instruction writes rd
- fwd_rd  in  FWD_STAGES*REG_AW  per-stage destination id
- fwd_we  in  FWD_STAGES  per-stage writes rd
- fwd_dvalid  in  FWD_STAGES  per-stage result available
- fwd_data  in  FWD_STAGES*XLEN  per-stage result
- retire_valid  in  1  writeback committed
- retire_rd  in  REG_AW  committed destination
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  operands valid to EXU
- out_ready  in  1  EXU accepts
- out_src1, out_src2  out  XLEN each  resolved operands
- out_rd  out  REG_AW  destination passed on
- out_rd_we  out  1  write-enable passed on
- sb_err  out  1  sticky: retire seen on a zero counter

Behaviour:
- Reset: all counters 0; out_valid=0; out_src1=out_src2=0; out_rd=0; out_rd_we=0; sb_err=0.
- Source hazard check, for source s with use=1 and id≠0:
  - Find the lowest-index stage k with fwd_we[k]=1 and fwd_rd[k]=id.
  - If stage k exists and fwd_dvalid[k]=1: forward fwd_data[k].
  - If stage k exists and fwd_dvalid[k]=0: hazard.
  - If no stage matches and pending[id]>0: hazard (writer outside window).
  - Otherwise: use the register data.
- Source with use=0 or id=0: never a hazard; operand passes in_srcX_reg unchanged.
- WAW overflow: in_rd_we=1, in_rd≠0 and pending[in_rd] at maximum → hazard.
- in_ready = !flush && !hazard && (!out_valid || out_ready). This is combinational.
- Issue fires when in_valid && in_ready. At the next edge:
  - the output slot loads the resolved operands, in_rd and in_rd_we;
  - out_valid=1;
  - pending[in_rd] increments if in_rd_we=1 and in_rd≠0.
- Output slot when not issuing: out_valid clears if out_valid && out_ready; otherwise it holds. While out_valid=1 && out_ready=0, data is stable.
- Retire fires on retire_valid with retire_rd≠0:
  - pending[retire_rd] decrements;
  - if pending is already 0, the counter stays 0 and sb_err sets (sticky until reset).
- Issue and retire on the same register in the same cycle: net counter change is 0.
- Flush, with priority over everything else:
  - all counters clear, out_valid clears, in_ready is 0;
  - retire in the same cycle is ignored;
  - sb_err is unaffected.
- Latency: one cycle from issue to out_valid.
- No combinational path from fwd_* or retire_* to out_* registers other than through issue.
- Reset asserted mid-operation: all state clears immediately (asynchronous); deassertion is synchronous to clk by the system.

Test Plan:
1. Reset, then issue rd=5 with in_rd_we=1 and out_ready=1 → out_valid=1 next cycle, pending[5]=1. Retire rd=5 → pending[5]=0, sb_err=0.
2. Forward hit: fwd_we[0]=1, fwd_rd[0]=3, fwd_dvalid[0]=1, data 0x1234; issue src1=3 → out_src1=0x1234. Set stage 2 to also match rd=3 with data 0xFFFF → youngest wins, result still 0x1234.
3. Load-use stall: fwd_rd[1]=7 with fwd_dvalid[1]=0; src2=7 → in_ready=0. Raise fwd_dvalid[1]=1 with data 0xAB → issue; out_src2=0xAB.
4. Out-of-window writer: pending[9]=1 with no fwd match; src1=9 → stall. Retire 9 → next cycle in_ready=1 and register data is used.
5. Saturation and simultaneous events: issue three writers to rd=4 (CNT_W=2) → fourth stalls. Issue rd=4 while retiring rd=4 at count 2 → count stays 2. src=0 with fwd_rd=0 → no stall, operand 0.
6. Back-pressure, flush and error: out_ready=0 → out_* stable and in_ready=0. Flush → out_valid=0 and counters 0. Retire rd=2 with pending 0 → sb_err=1, held through flush, cleared only by rst_n=0.
